seg_scan_ctrl: RTL and testbench

//  Parametrised multiplexed 7-segment driver: N-digit scan, hex or decimal mode, sequential
//  bin->BCD conversion, leading-zero blanking, overflow indication. Sits between CPU/MMIO

---
 rtl/seg_pkg.sv | 56 +++++
 rtl/bin2bcd_seq.sv | 62 ++++++
 rtl/seg_scan_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared FSM states, segment constants and helper functions for the 7-segment scan driver
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } seg_state_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Common-anode {dp,g..a}, active-low; dp is always off.
    function automatic logic [7:0] seg_encode(input logic [3:0] nibble);
        logic [7:0] code;
        case (nibble)
            4'h0: code = 8'hC0;
            4'h1: code = 8'hF9;
            4'h2: code = 8'hA4;
            4'h3: code = 8'hB0;
            4'h4: code = 8'h99;
            4'h5: code = 8'h92;
            4'h6: code = 8'h82;
            4'h7: code = 8'hF8;
            4'h8: code = 8'h80;
            4'h9: code = 8'h90;
            4'hA: code = 8'h88;
            4'hB: code = 8'h83;
            4'hC: code = 8'hC6;
            4'hD: code = 8'hA1;
            4'hE: code = 8'h86;
            default: code = 8'h8E;
        endcase
        return code;
    endfunction

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Largest value representable in the given number of decimal digits.
    function automatic logic [63:0] dec_max(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to BCD converter, one input bit per cycle
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_W-1:0]       bin,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = clog2(DATA_W + 1);

    logic [DATA_W-1:0] sh;
    logic [BCD_W-1:0]  acc;
    logic [BCD_W-1:0]  adj;
    logic [CNT_W-1:0]  cnt;
    logic              busy;

    // done marks the edge that consumes the last input bit; bcd is final from the next cycle.
    assign done = busy && (cnt == CNT_W'(1));
    assign bcd  = acc;

    // Add 3 to every digit that is 5 or more so the following shift carries correctly.
    always_comb begin
        adj = acc;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Shift one binary bit into the BCD accumulator per cycle; a carry out of the top digit
    // recirculates into the vacated low bits of sh, which are never shifted out again.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh   <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            sh   <= bin;
            acc  <= '0;
            cnt  <= CNT_W'(DATA_W);
            busy <= 1'b1;
        end else if (busy) begin
            acc <= {adj[BCD_W-2:0], sh[DATA_W-1]};
            sh  <= {sh[DATA_W-2:0], adj[BCD_W-1]};
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - N-digit multiplexed 7-segment scan driver (hex/decimal, blanking, overflow; blink with SEG_BLINK_EN)
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DATA_W     = 32,
    parameter int CLK_HZ     = 100_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter int BLINK_HZ   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     disp_data,
    input  logic                  disp_valid,
    input  logic                  disp_mode,
    input  logic                  blank_lz,
`ifdef SEG_BLINK_EN
    input  logic                  blink,
`endif
    output logic                  disp_ready,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] seg_an,
    output logic [7:0]            seg_seg
);

    localparam int          DIG_W    = 4 * NUM_DIGITS;
    localparam int          TICK_DIV = CLK_HZ / SCAN_HZ;
    localparam int          PRESC_W  = clog2(TICK_DIV);
    localparam int          IDX_W    = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
    localparam logic [63:0] DEC_MAX  = dec_max(NUM_DIGITS);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CONV = CONV;
    localparam logic [1:0] ST_LOAD = LOAD;

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("seg_scan_ctrl: NUM_DIGITS must be 1..8");
    end
    if (TICK_DIV < 2 || BLINK_HZ < 1) begin : g_bad_rates
        $error("seg_scan_ctrl: CLK_HZ/SCAN_HZ must be >= 2 and BLINK_HZ >= 1");
    end

    logic [1:0]            state;
    logic                  accept;
    logic                  hex_ov;
    logic                  dec_ov;
    logic [DIG_W-1:0]      hex_dig;
    logic [DIG_W-1:0]      lat_hex;
    logic                  lat_mode;
    logic                  lat_blank;
    logic                  lat_ov;
    logic [DIG_W-1:0]      shadow_dig;
    logic                  shadow_blank;
    logic                  bcd_done;
    logic [DIG_W-1:0]      bcd_val;
    logic [PRESC_W-1:0]    presc;
    logic [IDX_W-1:0]      idx;
    logic [NUM_DIGITS-1:0] lit;
    logic                  nz_above;
    logic [3:0]            cur_nib;
    logic [7:0]            cur_seg;
    logic                  blink_off;

    assign disp_ready = (state == ST_IDLE);
    assign accept     = disp_valid && disp_ready;
    assign dec_ov     = (64'(disp_data) > DEC_MAX);

    // Split the incoming word into displayable nibbles; any higher set bit is a hex overflow.
    always_comb begin
        hex_ov  = 1'b0;
        hex_dig = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < DIG_W) begin
                hex_dig[i] = disp_data[i];
            end else begin
                hex_ov = hex_ov | disp_data[i];
            end
        end
    end

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && disp_mode),
        .bin   (disp_data),
        .done  (bcd_done),
        .bcd   (bcd_val)
    );

    // Request FSM: capture settings on accept, convert if decimal, then publish to the shadow in LOAD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            lat_hex      <= '0;
            lat_mode     <= 1'b0;
            lat_blank    <= 1'b0;
            lat_ov       <= 1'b0;
            shadow_dig   <= '0;
            shadow_blank <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (disp_valid) begin
                        lat_hex   <= hex_dig;
                        lat_mode  <= disp_mode;
                        lat_blank <= blank_lz;
                        lat_ov    <= disp_mode ? dec_ov : hex_ov;
                        state     <= disp_mode ? ST_CONV : ST_LOAD;
                    end
                end
                ST_CONV: begin
                    if (bcd_done) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shadow_dig   <= lat_mode ? bcd_val : lat_hex;
                    shadow_blank <= lat_blank;
                    overflow     <= lat_ov;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Scan prescaler and digit index; the index advances once per prescaler wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRESC_W'(TICK_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    // A digit stays lit if it or any higher digit is nonzero; digit 0 is always lit.
    always_comb begin
        nz_above = 1'b0;
        lit      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz_above = nz_above | (shadow_dig[4*i +: 4] != 4'd0);
            lit[i]   = nz_above || (i == 0) || !shadow_blank;
        end
    end

    assign cur_nib = shadow_dig[{idx, 2'b00} +: 4];

    // Segment pattern for the digit currently selected by the scan index.
    always_comb begin
        if (overflow) begin
            cur_seg = SEG_DASH;
        end else if (!lit[idx]) begin
            cur_seg = SEG_BLANK;
        end else begin
            cur_seg = seg_encode(cur_nib);
        end
    end

`ifdef SEG_BLINK_EN
    localparam int BLINK_DIV = CLK_HZ / BLINK_HZ;
    localparam int BLINK_W   = clog2(BLINK_DIV);

    logic [BLINK_W-1:0] blink_cnt;

    // Free-running blink phase counter; the display is dark during the first half period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt <= '0;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    assign blink_off = blink && (blink_cnt < BLINK_W'(BLINK_DIV / 2));
`else
    assign blink_off = 1'b0;
`endif

    // Register anode and segment pins together so they never disagree on the pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_an  <= '1;
            seg_seg <= SEG_BLANK;
        end else if (blink_off) begin
            seg_an  <= '1;
            seg_seg <= SEG_BLANK;
        end else begin
            seg_an  <= ~(NUM_DIGITS'(1) << idx);
            seg_seg <= cur_seg;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl (8 digits, tick every 4 cycles)
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] disp_data = '0;
    logic        disp_valid = 1'b0;
    logic        disp_mode = 1'b0;
    logic        blank_lz = 1'b0;
    logic        disp_ready;
    logic        overflow;
    logic [7:0]  seg_an;
    logic [7:0]  seg_seg;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS (8),
        .DATA_W     (32),
        .CLK_HZ     (1000),
        .SCAN_HZ    (250)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .disp_mode  (disp_mode),
        .blank_lz   (blank_lz),
        .disp_ready (disp_ready),
        .overflow   (overflow),
        .seg_an     (seg_an),
        .seg_seg    (seg_seg)
    );

    logic [7:0] enc_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    typedef struct {
        string       name;
        logic [31:0] data;
        bit          mode;
        bit          blank;
        bit          exp_ov;
        int          exp_busy;
        logic [31:0] exp_dig;
        logic [7:0]  exp_lit;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [63:0] table_segs(input vec_t v);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            if (v.exp_ov) r[8*i +: 8] = 8'hBF;
            else if (v.exp_lit[i]) r[8*i +: 8] = enc_tab[v.exp_dig[4*i +: 4]];
            else r[8*i +: 8] = 8'hFF;
        end
        return r;
    endfunction

    function automatic bit model_ov(input logic [31:0] d, input bit m);
        longint unsigned v;
        v = 64'(d);
        return m && (v > 64'd99_999_999);
    endfunction

    // Reference: digits by division (decimal) or shifting (hex), then blanking/overflow rules.
    function automatic logic [63:0] model_segs(input logic [31:0] d, input bit m, input bit b);
        longint unsigned v, p;
        int dig [8];
        int hi;
        logic [63:0] r;
        v = 64'(d);
        p = 1;
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            dig[i] = m ? int'((v / p) % 64'd10) : int'((v >> (4 * i)) & 64'd15);
            p = p * 10;
            if (dig[i] != 0) hi = i;
        end
        for (int i = 0; i < 8; i++) begin
            if (model_ov(d, m)) r[8*i +: 8] = 8'hBF;
            else if (b && i > hi) r[8*i +: 8] = 8'hFF;
            else r[8*i +: 8] = enc_tab[dig[i][3:0]];
        end
        return r;
    endfunction

    // Issue one request and count cycles with disp_ready low; optional pulse / reset at a busy cycle.
    task automatic apply(input logic [31:0] d, input bit m, input bit b,
                         input int pulse_at, input int rst_at, output int busy);
        @(negedge clk);
        disp_data  = d;
        disp_mode  = m;
        blank_lz   = b;
        disp_valid = 1'b1;
        @(negedge clk);
        disp_valid = 1'b0;
        busy = 0;
        while (!disp_ready && busy < 100) begin
            busy++;
            if (busy == pulse_at) begin
                disp_valid = 1'b1;
                disp_data  = 32'd7;
                disp_mode  = 1'b0;
            end
            if (busy == rst_at) rst_n = 1'b0;
            @(negedge clk);
            disp_valid = 1'b0;
        end
    endtask

    // Watch the scan for 40 cycles: one digit low at a time, 4-cycle dwell, ascending order, segments.
    task automatic check_display(input logic [63:0] exp, input string name);
        logic [7:0] got [8];
        bit seen [8];
        bit bad_hot, bad_dwell, bad_order, counted;
        int d, prev_d, run;
        bad_hot = 0; bad_dwell = 0; bad_order = 0; counted = 0;
        prev_d = -1;
        run = 0;
        for (int i = 0; i < 8; i++) begin
            got[i] = 8'h00;
            seen[i] = 0;
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            d = -1;
            for (int i = 0; i < 8; i++) if (!seg_an[i]) d = i;
            if ($countones(~seg_an) != 1) bad_hot = 1;
            if (d >= 0 && !seen[d]) begin
                seen[d] = 1;
                got[d] = seg_seg;
            end
            if (d == prev_d) begin
                run++;
            end else begin
                if (counted && run != 4) bad_dwell = 1;
                if (prev_d != -1 && d != (prev_d + 1) % 8) bad_order = 1;
                counted = (prev_d != -1);
                prev_d = d;
                run = 1;
            end
        end
        chk({name, "_onehot"}, 64'(bad_hot), 64'd0);
        chk({name, "_dwell"}, 64'(bad_dwell), 64'd0);
        chk({name, "_order"}, 64'(bad_order), 64'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_dig%0d", name, i), 64'(got[i]), 64'(exp[8*i +: 8]));
        end
    endtask

    initial begin
        vec_t vecs [8];
        int busy;
        logic [31:0] rd;
        bit rm, rb;

        vecs[0] = '{"hex_a5c3",  32'h0000_A5C3,  1'b0, 1'b0, 1'b0, 1,  32'h0000_A5C3, 8'hFF};
        vecs[1] = '{"dec_12345", 32'd12345,      1'b1, 1'b1, 1'b0, 33, 32'h0001_2345, 8'h1F};
        vecs[2] = '{"dec_ovf",   32'd100_000_000, 1'b1, 1'b1, 1'b1, 33, 32'h0,         8'h00};
        vecs[3] = '{"dec_zero",  32'd0,          1'b1, 1'b1, 1'b0, 33, 32'h0,         8'h01};
        vecs[4] = '{"dec_max",   32'd99_999_999, 1'b1, 1'b0, 1'b0, 33, 32'h9999_9999, 8'hFF};
        vecs[5] = '{"hex_ffff",  32'hFFFF_FFFF,  1'b0, 1'b1, 1'b0, 1,  32'hFFFF_FFFF, 8'hFF};
        vecs[6] = '{"hex_0100",  32'h0000_0100,  1'b0, 1'b1, 1'b0, 1,  32'h0000_0100, 8'h07};
        vecs[7] = '{"hex_zero",  32'h0,          1'b0, 1'b1, 1'b0, 1,  32'h0,         8'h01};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_an", 64'(seg_an), 64'hFF);
        chk("rst_seg", 64'(seg_seg), 64'hFF);
        chk("rst_ready", 64'(disp_ready), 64'd1);
        chk("rst_ovf", 64'(overflow), 64'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            apply(vecs[k].data, vecs[k].mode, vecs[k].blank, 0, 0, busy);
            chk({vecs[k].name, "_busy"}, 64'(busy), 64'(vecs[k].exp_busy));
            chk({vecs[k].name, "_ovf"}, 64'(overflow), 64'(vecs[k].exp_ov));
            check_display(table_segs(vecs[k]), vecs[k].name);
        end

        apply(32'd12345, 1'b1, 1'b1, 5, 0, busy);
        chk("ignore_busy", 64'(busy), 64'd33);
        chk("ignore_ovf", 64'(overflow), 64'd0);
        check_display(model_segs(32'd12345, 1'b1, 1'b1), "ignore");

        apply(32'd987654, 1'b1, 1'b0, 0, 10, busy);
        chk("midrst_busy", 64'(busy), 64'd10);
        chk("midrst_an", 64'(seg_an), 64'hFF);
        chk("midrst_seg", 64'(seg_seg), 64'hFF);
        chk("midrst_ready", 64'(disp_ready), 64'd1);
        chk("midrst_ovf", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_display(model_segs(32'd0, 1'b0, 1'b0), "midrst");

        for (int k = 0; k < 16; k++) begin
            rm = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: rd = $urandom;
                1: rd = $urandom_range(0, 99_999_999);
                2: rd = $urandom >> $urandom_range(0, 31);
                default: rd = $urandom_range(99_999_990, 100_000_010);
            endcase
            apply(rd, rm, rb, 0, 0, busy);
            chk($sformatf("rnd%0d_busy", k), 64'(busy), rm ? 64'd33 : 64'd1);
            chk($sformatf("rnd%0d_ovf", k), 64'(overflow), 64'(model_ov(rd, rm)));
            check_display(model_segs(rd, rm, rb), $sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
